// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Shares one combinational ALU between a priority pipeline port
//             and an auxiliary port, with a starvation guard and a registered,
//             tagged response channel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  // port 0: pipeline EX stage
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_aluc,
  input  logic [TAG_W-1:0] req0_tag,
  // port 1: auxiliary unit
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_aluc,
  input  logic [TAG_W-1:0] req1_tag,
  // shared ALU
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [31:0]      alu_s,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  // status
  output logic [3:0]       wait_cnt,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_rsp_data;
  logic               r_rsp_id;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [3:0]         r_wait_cnt;
  logic [3:0]         w_wait_nxt;
  logic [CNT_W-1:0]   r_grant_cnt0;
  logic [CNT_W-1:0]   r_grant_cnt1;

  logic               w_can_issue;
  logic               w_gnt_valid;
  logic               w_gnt_id;
  logic               w_accept;
  logic [TAG_W-1:0]   w_gnt_tag;

  // Port 1 wins only when port 0 is idle or port 1 has starved long enough.
  always_comb begin
    w_can_issue = (r_state == ST_EMPTY) || rsp_ready;
    w_gnt_valid = req0_valid || req1_valid;
    w_gnt_id    = req1_valid && (!req0_valid || (r_wait_cnt >= c_max_wait));
    w_accept    = w_can_issue && w_gnt_valid;
  end

  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept &&  w_gnt_id;

  always_comb begin
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_aluc  = 4'b0000;
    w_gnt_tag = '0;
    if (w_gnt_valid) begin
      if (w_gnt_id) begin
        alu_a     = req1_a;
        alu_b     = req1_b;
        alu_aluc  = req1_aluc;
        w_gnt_tag = req1_tag;
      end else begin
        alu_a     = req0_a;
        alu_b     = req0_b;
        alu_aluc  = req0_aluc;
        w_gnt_tag = req0_tag;
      end
    end
  end

  // An accept always refills the response slot, so FULL only drains when idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_can_issue) begin
      if (!req1_valid || w_gnt_id)
        w_wait_nxt = 4'd0;
      else if (r_wait_cnt < c_max_wait)
        w_wait_nxt = r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_EMPTY;
      r_rsp_data   <= 32'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
      r_wait_cnt   <= 4'd0;
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_accept) begin
        r_rsp_data <= alu_s;
        r_rsp_id   <= w_gnt_id;
        r_rsp_tag  <= w_gnt_tag;
        if (w_gnt_id)
          r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
        else
          r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
      end
    end
  end

  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign rsp_tag    = r_rsp_tag;
  assign wait_cnt   = r_wait_cnt;
  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Directed self-checking bench for alu_share_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_a, req0_b;
  logic [3:0]       req0_aluc;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_a, req1_b;
  logic [3:0]       req1_aluc;
  logic [TAG_W-1:0] req1_tag;
  logic [31:0]      alu_a, alu_b, alu_s;
  logic [3:0]       alu_aluc;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Reference ALU: add, sub, and, or, popcount(a^b); others give 0.
  always_comb begin
    case (alu_aluc)
      4'b0000: alu_s = alu_a + alu_b;
      4'b0001: alu_s = alu_a - alu_b;
      4'b0010: alu_s = alu_a & alu_b;
      4'b0011: alu_s = alu_a | alu_b;
      4'b1011: alu_s = 32'($countones(alu_a ^ alu_b));
      default: alu_s = 32'd0;
    endcase
  end

  alu_share_arbiter #(.TAG_W(TAG_W), .MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_aluc(req0_aluc), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_aluc(req1_aluc), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .wait_cnt(wait_cnt),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic drive_idle();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0; req1_tag = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rsp_ready = 1'b1;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_tag !== 4'd0) begin
      bad++;
      $display("FAIL reset_rsp: valid=%b data=%h id=%b tag=%h want 0", rsp_valid, rsp_data, rsp_id, rsp_tag);
    end
    total++;
    if (wait_cnt !== 4'd0 || grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt: wait=%0d g0=%0d g1=%0d want 0", wait_cnt, grant_cnt0, grant_cnt1);
    end
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_a !== 32'd0 || alu_aluc !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: r0=%b r1=%b alu_a=%h aluc=%h want 0", req0_ready, req1_ready, alu_a, alu_aluc);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single_p0();
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluc = 4'b0000; req0_tag = 4'd2;
    #1;
    total++;
    if (req0_ready !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
      bad++;
      $display("FAIL p0_grant: ready=%b alu_a=%h alu_b=%h want 1/5/3", req0_ready, alu_a, alu_b);
    end
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_id !== 1'b0 || rsp_tag !== 4'd2) begin
      bad++;
      $display("FAIL p0_rsp: valid=%b data=%0d id=%b tag=%0d want 1/8/0/2", rsp_valid, rsp_data, rsp_id, rsp_tag);
    end
    total++;
    if (grant_cnt0 !== 8'd1) begin
      bad++;
      $display("FAIL p0_cnt: grant_cnt0=%0d want 1", grant_cnt0);
    end
    @(negedge clock);
    drive_idle();
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL p0_drain: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_single_p1();
    @(negedge clock);
    req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h00FF00FF; req1_aluc = 4'b1011; req1_tag = 4'd9;
    #1;
    total++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || alu_aluc !== 4'b1011) begin
      bad++;
      $display("FAIL p1_grant: r1=%b r0=%b aluc=%b want 1/0/1011", req1_ready, req0_ready, alu_aluc);
    end
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd32 || rsp_id !== 1'b1 || rsp_tag !== 4'd9) begin
      bad++;
      $display("FAIL p1_rsp: valid=%b data=%0d id=%b tag=%0d want 1/32/1/9", rsp_valid, rsp_data, rsp_id, rsp_tag);
    end
    total++;
    if (grant_cnt1 !== 8'd1 || grant_cnt0 !== 8'd1) begin
      bad++;
      $display("FAIL p1_cnt: g1=%0d g0=%0d want 1/1", grant_cnt1, grant_cnt0);
    end
    @(negedge clock);
    drive_idle();
    @(posedge clock);
  endtask

  task automatic test_starvation();
    logic [9:0] exp_g;
    int         exp_w [10];
    exp_g = 10'b10_0001_0000;
    exp_w = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_aluc = 4'b0000; req0_tag = 4'd3;
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_aluc = 4'b0001; req1_tag = 4'd7;
      rsp_ready  = 1'b1;
      #1;
      total++;
      if (wait_cnt !== 4'(exp_w[i]) || req1_ready !== exp_g[i] || req0_ready !== !exp_g[i]) begin
        bad++;
        $display("FAIL starve_grant[%0d]: wait=%0d r1=%b r0=%b want %0d/%b/%b",
                 i, wait_cnt, req1_ready, req0_ready, exp_w[i], exp_g[i], !exp_g[i]);
      end
      @(posedge clock); #1;
      total++;
      if (rsp_id !== exp_g[i] || rsp_data !== (exp_g[i] ? 32'd5 : 32'd2) ||
          rsp_tag !== (exp_g[i] ? 4'd7 : 4'd3) || rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL starve_rsp[%0d]: id=%b data=%0d tag=%0d valid=%b", i, rsp_id, rsp_data, rsp_tag, rsp_valid);
      end
    end
    total++;
    if (grant_cnt0 !== 8'd9 || grant_cnt1 !== 8'd3 || wait_cnt !== 4'd0) begin
      bad++;
      $display("FAIL starve_cnt: g0=%0d g1=%0d wait=%0d want 9/3/0", grant_cnt0, grant_cnt1, wait_cnt);
    end
    @(negedge clock);
    drive_idle();
    @(posedge clock);
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_aluc = 4'b0001; req0_tag = 4'd5;
    rsp_ready  = 1'b1;
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd6) begin
      bad++;
      $display("FAIL bp_accept: valid=%b data=%0d want 1/6", rsp_valid, rsp_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rsp_ready  = 1'b0;
      req0_a     = 32'd100;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_aluc = 4'b0000; req1_tag = 4'd1;
      #1;
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready[%0d]: r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
      end
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || rsp_id !== 1'b0 || rsp_tag !== 4'd5 ||
          grant_cnt0 !== 8'd10 || wait_cnt !== 4'd0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d id=%b tag=%0d g0=%0d wait=%0d",
                 i, rsp_valid, rsp_data, rsp_id, rsp_tag, grant_cnt0, wait_cnt);
      end
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: r0=%b r1=%b want 1/0", req0_ready, req1_ready);
    end
    @(posedge clock); #1;
    total++;
    if (rsp_data !== 32'd96 || wait_cnt !== 4'd1 || grant_cnt0 !== 8'd11) begin
      bad++;
      $display("FAIL bp_next: data=%0d wait=%0d g0=%0d want 96/1/11", rsp_data, wait_cnt, grant_cnt0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    rsp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || wait_cnt !== 4'd0 ||
        grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      bad++;
      $display("FAIL midreset: valid=%b data=%0d wait=%0d g0=%0d g1=%0d want 0",
               rsp_valid, rsp_data, wait_cnt, grant_cnt0, grant_cnt1);
    end
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_hold: rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge clock);
    drive_idle();
    rsp_ready = 1'b1;
    resetn    = 1'b1;
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0 || grant_cnt0 !== 8'd0) begin
      bad++;
      $display("FAIL midreset_stale: valid=%b g0=%0d want 0/0", rsp_valid, grant_cnt0);
    end
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      req0_valid = 1'b1; req0_a = 32'(i); req0_b = 32'd1; req0_aluc = 4'b0000; req0_tag = 4'(i);
      rsp_ready  = 1'b1;
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'(i + 1) || rsp_tag !== 4'(i)) begin
        bad++;
        $display("FAIL b2b[%0d]: valid=%b data=%0d tag=%0d want 1/%0d/%0d",
                 i, rsp_valid, rsp_data, rsp_tag, i + 1, i % 16);
      end
      if (i == 254) begin
        total++;
        if (grant_cnt0 !== 8'd255) begin
          bad++;
          $display("FAIL wrap_pre: grant_cnt0=%0d want 255", grant_cnt0);
        end
      end
    end
    total++;
    if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      bad++;
      $display("FAIL wrap: g0=%0d g1=%0d want 0/0", grant_cnt0, grant_cnt1);
    end
    @(negedge clock);
    drive_idle();
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd256) begin
      bad++;
      $display("FAIL wrap_drain: valid=%b data=%0d want 0/256", rsp_valid, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_p0();
    test_single_p1();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
